// File: rtl/bakraid_pkg.sv
// Shared definitions for the Bakraid extra-text layer memory controller:
// region encodings, default RAM geometry and the CPU FSM state type.
package bakraid_pkg;

  localparam int DEF_VRAM_AW = 12;
  localparam int DEF_LINE_AW = 8;
  localparam int RAM_RD_LAT  = 2;

  localparam logic [1:0] SEL_VRAM   = 2'd0;
  localparam logic [1:0] SEL_LINE   = 2'd1;
  localparam logic [1:0] SEL_SCROLL = 2'd2;
  localparam logic [1:0] SEL_NONE   = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD0,
    ST_RD1,
    ST_ACK,
    ST_CLEAR
  } state_t;

  // Unmapped region reads back as open bus (all ones).
  function automatic logic [15:0] sel_rdata(input logic [1:0]  sel,
                                            input logic [15:0] vram_q,
                                            input logic [15:0] line_q,
                                            input logic [15:0] scroll_q);
    case (sel)
      SEL_VRAM:   return vram_q;
      SEL_LINE:   return line_q;
      SEL_SCROLL: return scroll_q;
      default:    return 16'hFFFF;
    endcase
  endfunction

endpackage

// File: rtl/bakraid_dpram_be.sv
// True dual-port RAM: port A is a read-only renderer port with a two-register
// read path, port B is the shared CPU/clear port with byte-enable writes.
module bakraid_dpram_be #(
  parameter int AW     = 8,
  parameter int DATA_W = 16
) (
  input  logic                  CLK96,
  input  logic                  RESET96_N,
  input  logic [AW-1:0]         a_addr,
  output logic [DATA_W-1:0]     a_dout,
  input  logic [AW-1:0]         b_addr,
  input  logic                  b_we,
  input  logic [DATA_W/8-1:0]   b_be,
  input  logic [DATA_W-1:0]     b_din,
  output logic [DATA_W-1:0]     b_dout
);

  logic [DATA_W-1:0] mem [2**AW];
  logic [DATA_W-1:0] a_rd_p1;

  // Stage 1: array read on both ports; a colliding write lands after the read (old data).
  always_ff @(posedge CLK96) begin
    a_rd_p1 <= mem[a_addr];
    b_dout  <= mem[b_addr];
    if (b_we) begin
      for (int i = 0; i < DATA_W/8; i++) begin
        if (b_be[i]) mem[b_addr][i*8 +: 8] <= b_din[i*8 +: 8];
      end
    end
  end

  // Stage 2: renderer output register.
  always_ff @(posedge CLK96 or negedge RESET96_N) begin
    if (!RESET96_N) a_dout <= '0;
    else            a_dout <= a_rd_p1;
  end

endmodule

// File: rtl/bakraid_textram_ctrl.sv
// Text-layer memory responder: three renderer read ports at fixed latency,
// a 68k-style CPU access FSM and a full sweep-clear engine on the shared port B.
module bakraid_textram_ctrl
  import bakraid_pkg::*;
#(
  parameter int VRAM_AW = DEF_VRAM_AW,
  parameter int LINE_AW = DEF_LINE_AW
) (
  input  logic               CLK96,
  input  logic               RESET96_N,
  input  logic               CPU_CS,
  input  logic               CPU_RNW,
  input  logic [1:0]         CPU_SEL,
  input  logic [VRAM_AW-1:0] CPU_ADDR,
  input  logic               CPU_UDS,
  input  logic               CPU_LDS,
  input  logic [15:0]        CPU_DIN,
  output logic [15:0]        CPU_DOUT,
  output logic               CPU_ACK,
  input  logic               CLR_REQ,
  output logic               CLR_BUSY,
  input  logic [VRAM_AW-1:0] TEXTVRAM_ADDR,
  output logic [15:0]        TEXTVRAM_DATA,
  input  logic [LINE_AW-1:0] TEXTSELECT_ADDR,
  output logic [15:0]        TEXTSELECT_DATA,
  input  logic [LINE_AW-1:0] TEXTSCROLL_ADDR,
  output logic [15:0]        TEXTSCROLL_DATA
);

  state_t             state;
  logic [VRAM_AW-1:0] clr_cnt;
  logic               clr_pend;

  logic [VRAM_AW-1:0] vaddr_b;
  logic [LINE_AW-1:0] laddr_b;
  logic [1:0]         be_b;
  logic [15:0]        din_b;
  logic               we_vram, we_line, we_scroll;
  logic [15:0]        q_vram, q_line, q_scroll;

  // Port B belongs to the clear engine while sweeping, otherwise to the CPU write cycle.
  always_comb begin
    vaddr_b   = CPU_ADDR;
    laddr_b   = CPU_ADDR[LINE_AW-1:0];
    be_b      = {CPU_UDS, CPU_LDS};
    din_b     = CPU_DIN;
    we_vram   = (state == ST_WR) && (CPU_SEL == SEL_VRAM);
    we_line   = (state == ST_WR) && (CPU_SEL == SEL_LINE);
    we_scroll = (state == ST_WR) && (CPU_SEL == SEL_SCROLL);
    if (state == ST_CLEAR) begin
      vaddr_b   = clr_cnt;
      laddr_b   = clr_cnt[LINE_AW-1:0];
      be_b      = 2'b11;
      din_b     = 16'h0000;
      we_vram   = 1'b1;
      we_line   = (clr_cnt[VRAM_AW-1:LINE_AW] == '0);
      we_scroll = (clr_cnt[VRAM_AW-1:LINE_AW] == '0);
    end
  end

  always_ff @(posedge CLK96 or negedge RESET96_N) begin
    if (!RESET96_N) begin
      state    <= ST_IDLE;
      CPU_ACK  <= 1'b0;
      CPU_DOUT <= 16'h0000;
      CLR_BUSY <= 1'b0;
      clr_cnt  <= '0;
      clr_pend <= 1'b0;
    end else begin
      if (CLR_REQ && state != ST_IDLE && state != ST_CLEAR) clr_pend <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (CLR_REQ || clr_pend) begin
            state    <= ST_CLEAR;
            CLR_BUSY <= 1'b1;
            clr_pend <= 1'b0;
            clr_cnt  <= '0;
          end else if (CPU_CS && !CPU_ACK) begin
            state <= CPU_RNW ? ST_RD0 : ST_WR;
          end
        end
        ST_WR: begin
          state   <= ST_ACK;
          CPU_ACK <= 1'b1;
        end
        ST_RD0: state <= ST_RD1;
        ST_RD1: begin
          CPU_DOUT <= sel_rdata(CPU_SEL, q_vram, q_line, q_scroll);
          CPU_ACK  <= 1'b1;
          state    <= ST_ACK;
        end
        ST_ACK: begin
          if (!CPU_CS) begin
            CPU_ACK <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        ST_CLEAR: begin
          if (clr_cnt == '1) begin
            clr_cnt  <= '0;
            CLR_BUSY <= 1'b0;
            state    <= ST_IDLE;
          end else begin
            clr_cnt <= clr_cnt + VRAM_AW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  bakraid_dpram_be #(.AW(VRAM_AW), .DATA_W(16)) u_vram (
    .CLK96(CLK96), .RESET96_N(RESET96_N),
    .a_addr(TEXTVRAM_ADDR), .a_dout(TEXTVRAM_DATA),
    .b_addr(vaddr_b), .b_we(we_vram), .b_be(be_b), .b_din(din_b), .b_dout(q_vram)
  );

  bakraid_dpram_be #(.AW(LINE_AW), .DATA_W(16)) u_line (
    .CLK96(CLK96), .RESET96_N(RESET96_N),
    .a_addr(TEXTSELECT_ADDR), .a_dout(TEXTSELECT_DATA),
    .b_addr(laddr_b), .b_we(we_line), .b_be(be_b), .b_din(din_b), .b_dout(q_line)
  );

  bakraid_dpram_be #(.AW(LINE_AW), .DATA_W(16)) u_scroll (
    .CLK96(CLK96), .RESET96_N(RESET96_N),
    .a_addr(TEXTSCROLL_ADDR), .a_dout(TEXTSCROLL_DATA),
    .b_addr(laddr_b), .b_we(we_scroll), .b_be(be_b), .b_din(din_b), .b_dout(q_scroll)
  );

endmodule

// File: tb/tb_bakraid_textram_ctrl.sv
// Directed bench for bakraid_textram_ctrl: CPU handshake, renderer read
// latency via a scoreboard, sweep clear, clear latching and async reset.
module tb_bakraid_textram_ctrl;
  import bakraid_pkg::*;

  logic        CLK96 = 1'b0;
  logic        RESET96_N;
  logic        CPU_CS, CPU_RNW, CPU_UDS, CPU_LDS, CLR_REQ;
  logic [1:0]  CPU_SEL;
  logic [11:0] CPU_ADDR, TEXTVRAM_ADDR;
  logic [15:0] CPU_DIN, CPU_DOUT;
  logic        CPU_ACK, CLR_BUSY;
  logic [7:0]  TEXTSELECT_ADDR, TEXTSCROLL_ADDR;
  logic [15:0] TEXTVRAM_DATA, TEXTSELECT_DATA, TEXTSCROLL_DATA;

  bakraid_textram_ctrl dut (
    .CLK96(CLK96), .RESET96_N(RESET96_N),
    .CPU_CS(CPU_CS), .CPU_RNW(CPU_RNW), .CPU_SEL(CPU_SEL), .CPU_ADDR(CPU_ADDR),
    .CPU_UDS(CPU_UDS), .CPU_LDS(CPU_LDS), .CPU_DIN(CPU_DIN), .CPU_DOUT(CPU_DOUT),
    .CPU_ACK(CPU_ACK), .CLR_REQ(CLR_REQ), .CLR_BUSY(CLR_BUSY),
    .TEXTVRAM_ADDR(TEXTVRAM_ADDR), .TEXTVRAM_DATA(TEXTVRAM_DATA),
    .TEXTSELECT_ADDR(TEXTSELECT_ADDR), .TEXTSELECT_DATA(TEXTSELECT_DATA),
    .TEXTSCROLL_ADDR(TEXTSCROLL_ADDR), .TEXTSCROLL_DATA(TEXTSCROLL_DATA)
  );

  always #5 CLK96 = ~CLK96;

  typedef struct {
    int          due;
    int          port;
    logic [15:0] exp;
  } sb_t;

  sb_t         sbq[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [15:0] model_scr [256];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    sb_t e;
    @(posedge CLK96);
    #1;
    cyc++;
    while (sbq.size() > 0 && sbq[0].due <= cyc) begin
      e = sbq.pop_front();
      case (e.port)
        0:       chk("rd_vram",   TEXTVRAM_DATA,   e.exp);
        1:       chk("rd_select", TEXTSELECT_DATA, e.exp);
        default: chk("rd_scroll", TEXTSCROLL_DATA, e.exp);
      endcase
    end
  endtask

  task automatic rq(input int port, input logic [11:0] addr, input logic [15:0] exp);
    case (port)
      0:       TEXTVRAM_ADDR   = addr;
      1:       TEXTSELECT_ADDR = addr[7:0];
      default: TEXTSCROLL_ADDR = addr[7:0];
    endcase
    sbq.push_back('{cyc + RAM_RD_LAT, port, exp});
  endtask

  task automatic cpu_acc(input string tag, input logic rnw, input logic [1:0] sel,
                         input logic [11:0] addr, input logic [15:0] din,
                         input logic uds, input logic lds, output logic [15:0] dout);
    int n;
    CPU_CS = 1'b1; CPU_RNW = rnw; CPU_SEL = sel; CPU_ADDR = addr;
    CPU_DIN = din; CPU_UDS = uds; CPU_LDS = lds;
    n = 0;
    while (!CPU_ACK && n < 50) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, 16'(n), rnw ? 16'd3 : 16'd2);
    dout = CPU_DOUT;
    CPU_CS = 1'b0;
    tick();
    chk({tag, "_ackdrop"}, 16'(CPU_ACK), 16'd0);
  endtask

  initial begin
    logic [15:0] d;
    int n, busy_cnt, ack_cnt;

    RESET96_N = 1'b0;
    CPU_CS = 0; CPU_RNW = 0; CPU_SEL = 0; CPU_ADDR = 0; CPU_UDS = 0; CPU_LDS = 0;
    CPU_DIN = 0; CLR_REQ = 0; TEXTVRAM_ADDR = 0; TEXTSELECT_ADDR = 0; TEXTSCROLL_ADDR = 0;
    repeat (3) tick();
    chk("rst_ack",    16'(CPU_ACK),  16'd0);
    chk("rst_dout",   CPU_DOUT,      16'h0000);
    chk("rst_busy",   16'(CLR_BUSY), 16'd0);
    chk("rst_vdata",  TEXTVRAM_DATA,   16'h0000);
    chk("rst_sdata",  TEXTSELECT_DATA, 16'h0000);
    chk("rst_scdata", TEXTSCROLL_DATA, 16'h0000);
    RESET96_N = 1'b1;
    tick();

    // Clear and CPU read requested together: clear wins, read served afterwards.
    CLR_REQ = 1; CPU_CS = 1; CPU_RNW = 1; CPU_SEL = SEL_VRAM; CPU_ADDR = 12'h123;
    CPU_UDS = 1; CPU_LDS = 1;
    tick();
    CLR_REQ = 0;
    busy_cnt = 0; n = 0;
    while (!CPU_ACK && n < 5000) begin
      if (CLR_BUSY) busy_cnt++;
      tick();
      n++;
    end
    chk("clr_busy_len", 16'(busy_cnt), 16'd4096);
    chk("clr_ack_seen", 16'(CPU_ACK), 16'd1);
    chk("clr_busy_end", 16'(CLR_BUSY), 16'd0);
    chk("clr_rd_vram", CPU_DOUT, 16'h0000);
    CPU_CS = 0;
    tick();
    chk("clr_ackdrop", 16'(CPU_ACK), 16'd0);
    for (int i = 0; i < 256; i++) model_scr[i] = 16'h0000;
    rq(0, 12'h123, 16'h0000); rq(1, 12'h000, 16'h0000); rq(2, 12'h0FF, 16'h0000);
    tick();
    rq(0, 12'hFFF, 16'h0000); rq(1, 12'h0FF, 16'h0000);
    repeat (3) tick();

    // Full write then renderer read-back at fixed latency.
    cpu_acc("wr_beef", 0, SEL_VRAM, 12'h123, 16'hBEEF, 1, 1, d);
    rq(0, 12'h123, 16'hBEEF);
    repeat (3) tick();

    // Upper-byte-only write merges with existing low byte.
    cpu_acc("wr_1234", 0, SEL_VRAM, 12'h010, 16'h1234, 1, 1, d);
    cpu_acc("wr_ab00", 0, SEL_VRAM, 12'h010, 16'hAB00, 1, 0, d);
    cpu_acc("rd_ab34", 1, SEL_VRAM, 12'h010, 16'h0000, 1, 1, d);
    chk("rd_ab34_data", d, 16'hAB34);
    cpu_acc("wr_lo", 0, SEL_VRAM, 12'h011, 16'h1234, 1, 1, d);
    cpu_acc("wr_lo_b", 0, SEL_VRAM, 12'h011, 16'h00CD, 0, 1, d);
    rq(0, 12'h011, 16'h12CD);
    repeat (3) tick();

    // Line-select address truncation and CPU read-back.
    cpu_acc("wr_sel", 0, SEL_LINE, 12'hF22, 16'h7777, 1, 1, d);
    rq(1, 12'h022, 16'h7777);
    repeat (3) tick();
    cpu_acc("rd_sel", 1, SEL_LINE, 12'h022, 16'h0000, 1, 1, d);
    chk("rd_sel_data", d, 16'h7777);

    // Scroll streaming with a colliding CPU write at 0x40.
    cpu_acc("wr_s40", 0, SEL_SCROLL, 12'h040, 16'h5555, 1, 1, d); model_scr[8'h40] = 16'h5555;
    cpu_acc("wr_s10", 0, SEL_SCROLL, 12'h010, 16'h1111, 1, 1, d); model_scr[8'h10] = 16'h1111;
    cpu_acc("wr_sff", 0, SEL_SCROLL, 12'h0FF, 16'hFFEE, 1, 1, d); model_scr[8'hFF] = 16'hFFEE;
    CPU_RNW = 0; CPU_SEL = SEL_SCROLL; CPU_ADDR = 12'h040; CPU_DIN = 16'hA5A5;
    CPU_UDS = 1; CPU_LDS = 1;
    ack_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      rq(2, 12'(i), model_scr[i]);
      if (i == 8'h3F) CPU_CS = 1;
      tick();
      if (CPU_ACK) begin
        ack_cnt++;
        CPU_CS = 0;
      end
    end
    chk("stream_ack", 16'(ack_cnt), 16'd1);
    model_scr[8'h40] = 16'hA5A5;
    rq(2, 12'h040, model_scr[8'h40]);
    repeat (3) tick();

    // Clear requested during the ACK phase of a read.
    CPU_CS = 1; CPU_RNW = 1; CPU_SEL = SEL_VRAM; CPU_ADDR = 12'h123;
    n = 0;
    while (!CPU_ACK && n < 50) begin
      tick();
      n++;
    end
    chk("ackclr_lat", 16'(n), 16'd3);
    chk("ackclr_data", CPU_DOUT, 16'hBEEF);
    CLR_REQ = 1;
    tick();
    CLR_REQ = 0; CPU_CS = 0;
    tick();
    chk("ackclr_ackdrop", 16'(CPU_ACK), 16'd0);
    chk("ackclr_notyet", 16'(CLR_BUSY), 16'd0);
    tick();
    chk("ackclr_start", 16'(CLR_BUSY), 16'd1);
    repeat (10) tick();
    CLR_REQ = 1;
    tick();
    CLR_REQ = 0;
    n = 0;
    while (CLR_BUSY && n < 5000) begin
      tick();
      n++;
    end
    chk("ackclr_done", 16'(CLR_BUSY), 16'd0);
    repeat (3) tick();
    chk("clr_in_clr_ignored", 16'(CLR_BUSY), 16'd0);
    rq(0, 12'h123, 16'h0000); rq(1, 12'h022, 16'h0000); rq(2, 12'h040, 16'h0000);
    repeat (3) tick();

    // Reset in the middle of a sweep clear.
    cpu_acc("wr_050", 0, SEL_VRAM, 12'h050, 16'h3333, 1, 1, d);
    cpu_acc("wr_200", 0, SEL_VRAM, 12'h200, 16'h4242, 1, 1, d);
    TEXTVRAM_ADDR = 12'h200;
    CLR_REQ = 1;
    tick();
    CLR_REQ = 0;
    repeat (100) tick();
    chk("midclr_busy", 16'(CLR_BUSY), 16'd1);
    chk("midclr_vdata", TEXTVRAM_DATA, 16'h4242);
    #2;
    RESET96_N = 0;
    #1;
    chk("rst_mid_ack", 16'(CPU_ACK), 16'd0);
    chk("rst_mid_busy", 16'(CLR_BUSY), 16'd0);
    chk("rst_mid_vdata", TEXTVRAM_DATA, 16'h0000);
    chk("rst_mid_sdata", TEXTSELECT_DATA, 16'h0000);
    chk("rst_mid_scdata", TEXTSCROLL_DATA, 16'h0000);
    tick();
    RESET96_N = 1;
    tick();
    chk("rst_rel_busy", 16'(CLR_BUSY), 16'd0);
    cpu_acc("rd_none", 1, SEL_NONE, 12'h000, 16'h0000, 1, 1, d);
    chk("rd_none_data", d, 16'hFFFF);
    rq(0, 12'h200, 16'h4242);
    tick();
    rq(0, 12'h050, 16'h0000);
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
